// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared state encodings, opcode/funct constants, mux select
//                codes and ALU class codes for the multi-cycle controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_t;

    // Opcodes
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ADDIU = 6'h09;
    localparam logic [5:0] c_OP_SLTI  = 6'h0a;
    localparam logic [5:0] c_OP_SLTIU = 6'h0b;
    localparam logic [5:0] c_OP_ANDI  = 6'h0c;
    localparam logic [5:0] c_OP_LUI   = 6'h0f;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2b;

    // Funct codes
    localparam logic [5:0] c_FN_JR    = 6'h08;

    // PCSource codes
    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] c_PCSRC_RS     = 2'b11;

    // RegDst codes
    localparam logic [1:0] c_REGDST_RT = 2'b00;
    localparam logic [1:0] c_REGDST_RD = 2'b01;
    localparam logic [1:0] c_REGDST_RA = 2'b10;

    // MemtoReg codes
    localparam logic [1:0] c_M2R_ALUOUT = 2'b00;
    localparam logic [1:0] c_M2R_MDR    = 2'b01;
    localparam logic [1:0] c_M2R_PC     = 2'b10;

    // ALUSrcA / ALUSrcB codes
    localparam logic [1:0] c_SRCA_PC     = 2'b00;
    localparam logic [1:0] c_SRCA_RS     = 2'b01;
    localparam logic [1:0] c_SRCB_RT     = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR   = 2'b01;
    localparam logic [1:0] c_SRCB_IMM    = 2'b10;
    localparam logic [1:0] c_SRCB_IMMSH2 = 2'b11;

    // ALUOp[2:0] class codes
    localparam logic [2:0] c_ALUC_ADD   = 3'b000;
    localparam logic [2:0] c_ALUC_SUB   = 3'b001;
    localparam logic [2:0] c_ALUC_RTYPE = 3'b010;
    localparam logic [2:0] c_ALUC_AND   = 3'b100;
    localparam logic [2:0] c_ALUC_SLT   = 3'b101;

    // I-type ALU instructions that write back through S_WB
    function automatic logic is_imm_alu(input logic [5:0] op);
        return (op == c_OP_ADDI) || (op == c_OP_ADDIU) || (op == c_OP_SLTI) ||
               (op == c_OP_SLTIU) || (op == c_OP_ANDI) || (op == c_OP_LUI);
    endfunction

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == c_OP_RTYPE) || (op == c_OP_J) || (op == c_OP_JAL) ||
               (op == c_OP_BEQ) || (op == c_OP_BNE) || is_imm_alu(op) ||
               (op == c_OP_LW) || (op == c_OP_SW);
    endfunction

    function automatic logic is_legal_funct(input logic [5:0] fn);
        return (fn == 6'h00) || (fn == 6'h02) || (fn == 6'h03) || (fn == 6'h08) ||
               ((fn >= 6'h20) && (fn <= 6'h27)) || (fn == 6'h2a) || (fn == 6'h2b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_aluop_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_aluop_decode
//  Description : Maps state and opcode to the ALU operation class. Bit 3
//                carries OpCode[0] (unsigned / ne variants); bits above 3
//                are always zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_aluop_decode
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4
) (
    input  state_t             i_state,
    input  logic [5:0]         i_opcode,
    output logic [ALUOP_W-1:0] o_aluop
);

    logic [3:0] w_aluop4;

    // Class decode; fetch and decode always use the plain add class
    always_comb begin
        w_aluop4      = 4'b0000;
        w_aluop4[3]   = i_opcode[0];
        if ((i_state != S_IF) && (i_state != S_ID)) begin
            if (i_opcode == c_OP_RTYPE)
                w_aluop4[2:0] = c_ALUC_RTYPE;
            else if ((i_opcode == c_OP_BEQ) || (i_opcode == c_OP_BNE))
                w_aluop4[2:0] = c_ALUC_SUB;
            else if (i_opcode == c_OP_ANDI)
                w_aluop4[2:0] = c_ALUC_AND;
            else if ((i_opcode == c_OP_SLTI) || (i_opcode == c_OP_SLTIU))
                w_aluop4[2:0] = c_ALUC_SLT;
            else
                w_aluop4[2:0] = c_ALUC_ADD;
        end
    end

    generate
        if (ALUOP_W > 4) begin : g_wide
            assign o_aluop = {{(ALUOP_W-4){1'b0}}, w_aluop4};
        end else begin : g_narrow
            assign o_aluop = w_aluop4;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/multicycle_controller_v2.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller_v2
//  Description : Multi-cycle MIPS control FSM. Decodes OpCode/Funct and the
//                current state into datapath selects, waits on mem_ready in
//                IF and MEM, and counts retired instructions.
//                Build option: define ILLEGAL_OP_TRAP_EN to route illegal
//                opcodes / R-type functs through a one-cycle S_TRAP.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller_v2
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W       = 4,
    parameter int CNT_W         = 32,
    parameter int USE_MEM_READY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         OpCode,
    input  logic [5:0]         Funct,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               BranchNe,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         MemtoReg,
    output logic [1:0]         RegDst,
    output logic               RegWrite,
    output logic               ExtOp,
    output logic               LuiOp,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSource,
    output logic               trap,
    output logic [CNT_W-1:0]   retired
);

    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [CNT_W-1:0]   r_retired;
    logic [ALUOP_W-1:0] w_aluop;
    logic               w_mem_ready;
    logic               w_rtype;
    logic               w_jr;
    logic               w_imm_alu;
    logic               w_ldst;
    logic               w_ext_imm;
    logic               w_illegal;

    assign w_mem_ready = (USE_MEM_READY == 0) ? 1'b1 : mem_ready;
    assign w_rtype     = (OpCode == c_OP_RTYPE);
    assign w_jr        = w_rtype && (Funct == c_FN_JR);
    assign w_imm_alu   = is_imm_alu(OpCode);
    assign w_ldst      = (OpCode == c_OP_LW) || (OpCode == c_OP_SW);
    // Sign extension for everything that takes an immediate except andi
    assign w_ext_imm   = (w_imm_alu && (OpCode != c_OP_ANDI)) || w_ldst;

`ifdef ILLEGAL_OP_TRAP_EN
    assign w_illegal = !is_legal_op(OpCode) || (w_rtype && !is_legal_funct(Funct));
    assign trap      = reset && (r_state == S_TRAP);
`else
    assign w_illegal = 1'b0;
    assign trap      = 1'b0;
`endif

    assign retired = r_retired;

    ctrl_aluop_decode #(
        .ALUOP_W (ALUOP_W)
    ) u_aluop (
        .i_state  (r_state),
        .i_opcode (OpCode),
        .o_aluop  (w_aluop)
    );

    assign ALUOp = reset ? w_aluop : '0;

    // State sequencing and retire counting; every return to IF from EX/MEM/WB retires
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IF;
            r_retired <= '0;
        end else begin
            case (r_state)
                S_IF: if (w_mem_ready) r_state <= S_ID;
                S_ID: r_state <= S_EX;
                S_EX: begin
                    if (w_illegal)
                        r_state <= S_TRAP;
                    else if ((w_rtype && !w_jr) || w_imm_alu)
                        r_state <= S_WB;
                    else if (w_ldst)
                        r_state <= S_MEM;
                    else begin
                        r_state   <= S_IF;
                        r_retired <= r_retired + c_ONE;
                    end
                end
                S_MEM: begin
                    if (w_mem_ready) begin
                        if (OpCode == c_OP_LW)
                            r_state <= S_WB;
                        else begin
                            r_state   <= S_IF;
                            r_retired <= r_retired + c_ONE;
                        end
                    end
                end
                S_WB: begin
                    r_state   <= S_IF;
                    r_retired <= r_retired + c_ONE;
                end
                default: r_state <= S_IF;
            endcase
        end
    end

    // Output decode; everything held at zero while reset is low
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = c_M2R_ALUOUT;
        RegDst      = c_REGDST_RT;
        RegWrite    = 1'b0;
        ExtOp       = 1'b0;
        LuiOp       = 1'b0;
        ALUSrcA     = c_SRCA_PC;
        ALUSrcB     = c_SRCB_RT;
        PCSource    = c_PCSRC_ALU;
        if (reset) begin
            case (r_state)
                S_IF: begin
                    MemRead  = 1'b1;
                    ALUSrcB  = c_SRCB_FOUR;
                    IRWrite  = w_mem_ready;
                    PCWrite  = w_mem_ready;
                end
                S_ID: begin
                    ALUSrcB = c_SRCB_IMMSH2;
                    ExtOp   = 1'b1;
                end
                S_EX: begin
                    if (w_jr) begin
                        PCWrite  = 1'b1;
                        PCSource = c_PCSRC_RS;
                    end else if (w_rtype) begin
                        ALUSrcA = c_SRCA_RS;
                        ALUSrcB = c_SRCB_RT;
                    end else if ((OpCode == c_OP_J) || (OpCode == c_OP_JAL)) begin
                        PCWrite  = 1'b1;
                        PCSource = c_PCSRC_JUMP;
                        if (OpCode == c_OP_JAL) begin
                            RegWrite = 1'b1;
                            RegDst   = c_REGDST_RA;
                            MemtoReg = c_M2R_PC;
                        end
                    end else if ((OpCode == c_OP_BEQ) || (OpCode == c_OP_BNE)) begin
                        PCWriteCond = 1'b1;
                        ALUSrcA     = c_SRCA_RS;
                        ALUSrcB     = c_SRCB_RT;
                        PCSource    = c_PCSRC_ALUOUT;
                        BranchNe    = OpCode[0];
                    end else if (w_imm_alu || w_ldst) begin
                        ALUSrcA = c_SRCA_RS;
                        ALUSrcB = c_SRCB_IMM;
                        ExtOp   = w_ext_imm;
                        LuiOp   = (OpCode == c_OP_LUI);
                    end
                end
                S_MEM: begin
                    IorD     = 1'b1;
                    MemRead  = (OpCode == c_OP_LW);
                    MemWrite = (OpCode == c_OP_SW);
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    if (w_rtype) begin
                        RegDst   = c_REGDST_RD;
                        MemtoReg = c_M2R_ALUOUT;
                    end else if (OpCode == c_OP_LW) begin
                        RegDst   = c_REGDST_RT;
                        MemtoReg = c_M2R_MDR;
                    end
                    ExtOp = w_ext_imm;
                    LuiOp = (OpCode == c_OP_LUI);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
